// File: rtl/nreg_pipe.sv
// nreg_pipe: DEPTH-stage valid/ready register pipeline with flush.
// Each stage holds a word and a valid bit. A stage advances when it is empty
// or when the stage downstream of it advances, so bubbles collapse under
// backpressure and throughput stays at one word per cycle.
// Optional feature: define NREG_PIPE_CNT_EN to add the io_count occupancy port.
module nreg_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           io_D,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  output logic [WIDTH-1:0]           io_Q,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  input  logic                       io_flush
`ifdef NREG_PIPE_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] io_count
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv;
  logic             in_fire;

  // Advance chain, walked from the output back to the input stage.
  always_comb begin
    logic a;
    adv          = '0;
    a            = !valid_q[DEPTH-1] || io_out_ready;
    adv[DEPTH-1] = a;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      a      = !valid_q[i] || a;
      adv[i] = a;
    end
  end

  // Input handshake; a flush cycle never takes a word.
  always_comb begin
    io_in_ready = adv[0] && !io_flush;
    in_fire     = io_in_valid && io_in_ready;
  end

  // Next-state: shift valid bits on advance, load data only from valid words.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv[0]) begin
      valid_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = io_D;
      end
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
    // Flush drops every stored word but leaves the data registers untouched.
    if (io_flush) begin
      valid_d = '0;
      data_d  = data_q;
    end
  end

  // Stage registers; reset clears both data and valid immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Last stage drives the consumer side straight from its registers.
  always_comb begin
    io_Q         = data_q[DEPTH-1];
    io_out_valid = valid_q[DEPTH-1];
  end

`ifdef NREG_PIPE_CNT_EN
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Occupancy is the population count of the next valid vector.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  // Occupancy register, updated on the same edge as the valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign io_count = count_q;
`endif

endmodule

// File: tb/tb_nreg_pipe.sv
// Testbench for nreg_pipe: directed vectors on a WIDTH=8/DEPTH=2 instance,
// plus random valid/ready streams on DEPTH=1 and DEPTH=16 instances.
`timescale 1ns/1ps
module tb_nreg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rn2;
  logic       rn_r;
  logic [7:0] d2;
  logic [7:0] q2;
  logic       iv2;
  logic       ir2;
  logic       ov2;
  logic       or2;
  logic       fl2;
  logic [7:0] sbq [$];
`ifdef NREG_PIPE_CNT_EN
  logic [1:0] cnt2;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  nreg_pipe #(.WIDTH(8), .DEPTH(2)) u_dut2 (
    .clk          (clk),
    .reset_n      (rn2),
    .io_D         (d2),
    .io_in_valid  (iv2),
    .io_in_ready  (ir2),
    .io_Q         (q2),
    .io_out_valid (ov2),
    .io_out_ready (or2),
    .io_flush     (fl2)
`ifdef NREG_PIPE_CNT_EN
    ,
    .io_count     (cnt2)
`endif
  );

  // Scoreboard monitor for the directed instance: pops on every output transfer.
  always @(negedge clk) begin
    if (rn2 && ov2 && or2 && !fl2) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dir_unexpected_word: got 0x%0h expected no output", q2);
      end else begin
        chk("dir_out_word", 64'(q2), 64'(sbq.pop_front()));
      end
    end
  end

  // Random streams on DEPTH=1 and DEPTH=16.
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int DP = (g == 0) ? 1 : 16;
    logic [7:0] d;
    logic [7:0] q;
    logic       iv;
    logic       ir;
    logic       ov;
    logic       ordy;
    logic       done;
    logic [7:0] mq [$];
`ifdef NREG_PIPE_CNT_EN
    logic [$clog2(DP+1)-1:0] cnt;
`endif

    nreg_pipe #(.WIDTH(8), .DEPTH(DP)) u_dut (
      .clk          (clk),
      .reset_n      (rn_r),
      .io_D         (d),
      .io_in_valid  (iv),
      .io_in_ready  (ir),
      .io_Q         (q),
      .io_out_valid (ov),
      .io_out_ready (ordy),
      .io_flush     (1'b0)
`ifdef NREG_PIPE_CNT_EN
      ,
      .io_count     (cnt)
`endif
    );

    // Model: stored words = accepted minus delivered; full only at DP words.
    always @(negedge clk) begin
      int sz;
      if (rn_r) begin
        sz = mq.size();
        chk($sformatf("rand%0d_in_ready", DP), 64'(ir), 64'((sz < DP) || ordy));
`ifdef NREG_PIPE_CNT_EN
        chk($sformatf("rand%0d_count", DP), 64'(cnt), 64'(sz));
        chk($sformatf("rand%0d_count_le_depth", DP), 64'(int'(cnt) <= DP), 64'd1);
`endif
        if (ov && ordy) begin
          if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL rand%0d_unexpected_word: got 0x%0h expected no output", DP, q);
          end else begin
            chk($sformatf("rand%0d_out_word", DP), 64'(q), 64'(mq.pop_front()));
          end
        end
        if (iv && ir) begin
          mq.push_back(d);
        end
      end
    end

    initial begin
      done = 1'b0;
      iv   = 1'b0;
      ordy = 1'b0;
      d    = 8'h00;
      wait (rn_r);
      repeat (1000) begin
        @(posedge clk);
        #1;
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        d    = 8'($urandom);
      end
      @(posedge clk);
      #1;
      iv   = 1'b0;
      ordy = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk($sformatf("rand%0d_drained", DP), 64'(mq.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence on the DEPTH=2 instance.
  initial begin
    rn2 = 1'b0;
    rn_r = 1'b0;
    d2 = 8'h00;
    iv2 = 1'b0;
    or2 = 1'b0;
    fl2 = 1'b0;
    #2;
    chk("rst_out_valid", 64'(ov2), 64'd0);
    chk("rst_q", 64'(q2), 64'd0);
    chk("rst_in_ready", 64'(ir2), 64'd1);
`ifdef NREG_PIPE_CNT_EN
    chk("rst_count", 64'(cnt2), 64'd0);
`endif
    #10;
    rn2  = 1'b1;
    rn_r = 1'b1;

    // Streaming with no stall: two-cycle latency, one word per cycle.
    step();
    iv2 = 1'b1;
    or2 = 1'b1;
    d2  = 8'h11;
    sbq.push_back(8'h11);
    sbq.push_back(8'h22);
    sbq.push_back(8'h33);
    #1;
    chk("stream_in_ready", 64'(ir2), 64'd1);
    step();
    chk("stream_latency_empty", 64'(ov2), 64'd0);
    d2 = 8'h22;
    step();
    chk("stream_q0_valid", 64'(ov2), 64'd1);
    chk("stream_q0", 64'(q2), 64'h11);
    d2 = 8'h33;
    step();
    chk("stream_q1", 64'(q2), 64'h22);
    iv2 = 1'b0;
    step();
    chk("stream_q2", 64'(q2), 64'h33);
    step();
    chk("stream_drained", 64'(ov2), 64'd0);

    // Backpressure: fill, refuse a third word, then drain in order.
    or2 = 1'b0;
    iv2 = 1'b1;
    d2  = 8'hA5;
    sbq.push_back(8'hA5);
    sbq.push_back(8'h5A);
    step();
    d2 = 8'h5A;
    step();
    chk("full_in_ready", 64'(ir2), 64'd0);
    chk("full_q", 64'(q2), 64'hA5);
    chk("full_out_valid", 64'(ov2), 64'd1);
`ifdef NREG_PIPE_CNT_EN
    chk("full_count", 64'(cnt2), 64'd2);
`endif
    d2 = 8'h77;
    step();
    chk("stall_hold_q", 64'(q2), 64'hA5);
    chk("stall_in_ready", 64'(ir2), 64'd0);
    iv2 = 1'b0;
    or2 = 1'b1;
    step();
    chk("bp_q1", 64'(q2), 64'h5A);
    step();
    chk("bp_drained", 64'(ov2), 64'd0);

    // Full pipeline: accept a new word on the same edge the head leaves.
    or2 = 1'b0;
    iv2 = 1'b1;
    d2  = 8'h01;
    sbq.push_back(8'h01);
    sbq.push_back(8'h02);
    sbq.push_back(8'hC3);
    step();
    d2 = 8'h02;
    step();
    d2  = 8'hC3;
    or2 = 1'b1;
    #1;
    chk("simul_in_ready", 64'(ir2), 64'd1);
    step();
    chk("simul_q", 64'(q2), 64'h02);
    chk("simul_out_valid", 64'(ov2), 64'd1);
    iv2 = 1'b0;
    step();
    chk("simul_q_c3", 64'(q2), 64'hC3);
    step();
    chk("simul_drained", 64'(ov2), 64'd0);

    // Flush with two stored words and a pending 0xFF input.
    or2 = 1'b0;
    iv2 = 1'b1;
    d2  = 8'h31;
    step();
    d2 = 8'h32;
    step();
    fl2 = 1'b1;
    or2 = 1'b1;
    d2  = 8'hFF;
    #1;
    chk("flush_in_ready", 64'(ir2), 64'd0);
    step();
    fl2 = 1'b0;
    iv2 = 1'b0;
    chk("flush_out_valid", 64'(ov2), 64'd0);
`ifdef NREG_PIPE_CNT_EN
    chk("flush_count", 64'(cnt2), 64'd0);
`endif
    step();
    step();
    chk("flush_no_ff", 64'(ov2), 64'd0);

    // Asynchronous reset pulse between edges with two words in flight.
    or2 = 1'b0;
    iv2 = 1'b1;
    d2  = 8'h41;
    step();
    d2 = 8'h42;
    step();
    iv2 = 1'b0;
    chk("pre_rst_valid", 64'(ov2), 64'd1);
    #1;
    rn2 = 1'b0;
    #1;
    chk("rst_pulse_valid", 64'(ov2), 64'd0);
    chk("rst_pulse_q", 64'(q2), 64'd0);
`ifdef NREG_PIPE_CNT_EN
    chk("rst_pulse_count", 64'(cnt2), 64'd0);
`endif
    #3;
    rn2 = 1'b1;
    step();
    iv2 = 1'b1;
    or2 = 1'b1;
    d2  = 8'h55;
    sbq.push_back(8'h55);
    step();
    chk("post_rst_latency", 64'(ov2), 64'd0);
    iv2 = 1'b0;
    step();
    chk("post_rst_valid", 64'(ov2), 64'd1);
    chk("post_rst_q", 64'(q2), 64'h55);
    step();
    chk("post_rst_drained", 64'(ov2), 64'd0);

    wait (g_rand[0].done && g_rand[1].done);
    chk("dir_scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
